// File: rtl/mult_arbiter_pkg.sv
// ============================================================================
// Module      : mult_arbiter_pkg
// Description : Shared FSM encoding and port identifiers for mult_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/array_mult_core.sv
// ============================================================================
// Module      : array_mult_core
// Description : Combinational unsigned N x M array multiplier (shifted partial
//               products accumulated along a summation chain).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_mult_core #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  output logic [N+M-1:0] p_o
);

  logic [N+M-1:0] w_pp  [0:M-1];
  logic [N+M-1:0] w_sum [0:M];

  assign w_sum[0] = '0;

  // Row j contributes a shifted by j when bit j of b is set.
  for (genvar j = 0; j < M; j++) begin : g_row
    assign w_pp[j]    = b_i[j] ? ((N+M)'(a_i) << j) : '0;
    assign w_sum[j+1] = w_sum[j] + w_pp[j];
  end

  assign p_o = w_sum[M];

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one array multiplier between two
//               req/done requesters; registers operands and product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [M-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [M-1:0]   b1,
  output logic           done0,
  output logic           done1,
  output logic [N+M-1:0] y,
  output logic           busy
);

  import mult_arbiter_pkg::*;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           ptr_q,   ptr_d;
  logic [N-1:0]   a_q,     a_d;
  logic [M-1:0]   b_q,     b_d;
  logic [N+M-1:0] y_q,     y_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;

  logic           w_winner;
  logic           w_owner_req;
  logic [N+M-1:0] w_prod;

  array_mult_core #(.N(N), .M(M)) u_core (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (w_prod)
  );

  assign w_owner_req = (owner_q == P1) ? req1 : req0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    w_winner = P0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Pointer only breaks ties; a lone requester always wins.
          if (req0 && req1) w_winner = ptr_q;
          else if (req1)    w_winner = P1;
          else              w_winner = P0;
          owner_d = w_winner;
          a_d     = (w_winner == P1) ? a1 : a0;
          b_d     = (w_winner == P1) ? b1 : b0;
          state_d = MUL;
        end
      end
      MUL: begin
        y_d = w_prod;
        if (owner_q == P1) done1_d = 1'b1;
        else               done0_d = 1'b1;
        ptr_d   = ~owner_q;
        state_d = DONE;
      end
      DONE: begin
        if (!w_owner_req) begin
          done0_d = 1'b0;
          done1_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= P0;
      ptr_q   <= P0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign y     = y_q;
  assign busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Directed self-checking bench for mult_arbiter (N=M=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

  localparam int N = 4;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0, req1;
  logic [N-1:0]   a0, a1;
  logic [M-1:0]   b0, b1;
  logic           done0, done1;
  logic [N+M-1:0] y;
  logic           busy;

  int num_checks = 0;
  int num_fail   = 0;

  mult_arbiter #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .done0 (done0),
    .done1 (done1),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(); tick();
    num_checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      num_fail++;
      $display("FAIL reset_flags: done0/done1/busy=%b required 000", {done0, done1, busy});
    end
    num_checks++;
    if (y !== 8'd0) begin
      num_fail++;
      $display("FAIL reset_y: y=%0d required 0", y);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req0 = 1; a0 = 4'd13; b0 = 4'd11;
    tick();
    num_checks++;
    if (busy !== 1'b1 || done0 !== 1'b0) begin
      num_fail++;
      $display("FAIL single_busy: busy=%b done0=%b required busy=1 done0=0", busy, done0);
    end
    tick();
    num_checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || y !== 8'd143) begin
      num_fail++;
      $display("FAIL single_done: done0=%b done1=%b y=%0d required 1 0 143", done0, done1, y);
    end
    tick();
    num_checks++;
    if (done0 !== 1'b1) begin
      num_fail++;
      $display("FAIL single_hold: done0=%b required 1 while req0 high", done0);
    end
    req0 = 0;
    tick();
    num_checks++;
    if (done0 !== 1'b0 || busy !== 1'b0 || y !== 8'd143) begin
      num_fail++;
      $display("FAIL single_release: done0=%b busy=%b y=%0d required 0 0 143", done0, busy, y);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0 = 1; a0 = 4'd3; b0 = 4'd5;
    req1 = 1; a1 = 4'd7; b1 = 4'd9;
    tick(); tick();
    num_checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || y !== 8'd15) begin
      num_fail++;
      $display("FAIL simul_first: done0=%b done1=%b y=%0d required 1 0 15", done0, done1, y);
    end
    req0 = 0;
    tick();
    tick();
    tick();
    num_checks++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || y !== 8'd63) begin
      num_fail++;
      $display("FAIL simul_second: done1=%b done0=%b y=%0d required 1 0 63", done1, done0, y);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_y;
    logic       got_port;
    bit         seen;
    a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd5;
    req0 = 1; req1 = 1;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (done0 || done1) seen = 1;
      end
      num_checks++;
      if (!seen) begin
        num_fail++;
        $display("FAIL rr_timeout: grant %0d no done within 10 cycles, required a done", g);
      end else begin
        got_port = done1;
        exp_y    = (g % 2 == 0) ? 8'd6 : 8'd20;
        num_checks++;
        if (got_port !== 1'(g % 2) || (done0 & done1) || y !== exp_y) begin
          num_fail++;
          $display("FAIL rr_grant: grant %0d port=%0d both=%b y=%0d required port=%0d y=%0d",
                   g, got_port, done0 & done1, y, g % 2, exp_y);
        end
        if (got_port) req1 = 0; else req0 = 0;
        tick();
        req0 = 1; req1 = 1;
      end
    end
    req0 = 0; req1 = 0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_boundaries();
    req0 = 1; a0 = 4'd15; b0 = 4'd15;
    tick(); tick();
    num_checks++;
    if (done0 !== 1'b1 || y !== 8'd225) begin
      num_fail++;
      $display("FAIL max_product: done0=%b y=%0d required 1 225", done0, y);
    end
    req0 = 0;
    tick();
    do_reset();
    req1 = 1; a1 = 4'd0; b1 = 4'd9;
    tick();
    num_checks++;
    if (busy !== 1'b1) begin
      num_fail++;
      $display("FAIL lone_p1_busy: busy=%b required 1", busy);
    end
    tick();
    num_checks++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || y !== 8'd0) begin
      num_fail++;
      $display("FAIL zero_p1: done1=%b done0=%b y=%0d required 1 0 0", done1, done0, y);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_operand_change();
    req0 = 1; a0 = 4'd13; b0 = 4'd11;
    tick();
    a0 = 4'd2;
    tick();
    num_checks++;
    if (done0 !== 1'b1 || y !== 8'd143) begin
      num_fail++;
      $display("FAIL operand_change: done0=%b y=%0d required 1 143", done0, y);
    end
    req0 = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1; a0 = 4'd6; b0 = 4'd7;
    tick();
    rst_n = 1'b0;
    tick();
    num_checks++;
    if (done0 !== 1'b0 || y !== 8'd0 || busy !== 1'b0) begin
      num_fail++;
      $display("FAIL reset_mid: done0=%b y=%0d busy=%b required 0 0 0", done0, y, busy);
    end
    req0 = 0; req1 = 1; a1 = 4'd5; b1 = 4'd5;
    rst_n = 1'b1;
    tick();
    num_checks++;
    if (busy !== 1'b1) begin
      num_fail++;
      $display("FAIL post_reset_busy: busy=%b required 1", busy);
    end
    tick();
    num_checks++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || y !== 8'd25) begin
      num_fail++;
      $display("FAIL post_reset_p1: done1=%b done0=%b y=%0d required 1 0 25", done1, done0, y);
    end
    req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_boundaries();
    test_operand_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
